// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 11-symbol UART deframer with optional even parity, 7/8-bit data,
// fill/stop checking, sampled mid-symbol on an OVS x baud strobe.
module uart_frame_rx #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_in,
  input  logic       i_sample_tick,
  input  logic       i_sw0,
  input  logic       i_sw1,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);
  localparam int TW = $clog2(OVS);
  typedef enum logic [2:0] {IDLE, START, SHIFT, STOP, WAIT_HIGH} state_t;
  state_t      r_state;
  logic        r_sync1, r_sync2;
  logic [TW-1:0] r_tick;
  logic [3:0]  r_sym;
  logic [7:0]  r_shift;
  logic        r_par_acc, r_w8, r_pon, r_perr_p, r_ferr_p;
  logic        w_mid, w_last, w_is_data, w_is_par, w_is_fill;
  logic [3:0]  w_nd;
  assign w_mid     = r_tick == TW'(OVS / 2 - 1);
  assign w_last    = r_tick == TW'(OVS - 1);
  assign w_nd      = r_w8 ? 4'd8 : 4'd7;
  assign w_is_data = r_sym <= w_nd;
  assign w_is_par  = r_sym == w_nd + 4'd1;
  assign w_is_fill = !r_w8 && r_sym == 4'd9;
  // r_sync2 is the synchronized line; everything downstream looks only at it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_tick       <= '0;
      r_sym        <= '0;
      r_shift      <= '0;
      r_par_acc    <= 1'b0;
      r_w8         <= 1'b0;
      r_pon        <= 1'b0;
      r_perr_p     <= 1'b0;
      r_ferr_p     <= 1'b0;
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      r_sync1    <= i_rx_in;
      r_sync2    <= r_sync1;
      o_rx_valid <= 1'b0;
      case (r_state)
        IDLE: if (!r_sync2) begin
          r_state <= START;
          o_busy  <= 1'b1;
          r_tick  <= '0;
          r_w8    <= i_sw1;
          r_pon   <= i_sw0;
        end
        START: if (i_sample_tick) begin
          r_tick <= r_tick + TW'(1);
          if (w_mid) begin
            r_tick <= '0;
            if (r_sync2) begin
              r_state <= IDLE;
              o_busy  <= 1'b0;
            end else begin
              r_state   <= SHIFT;
              r_sym     <= 4'd1;
              r_shift   <= '0;
              r_par_acc <= 1'b0;
              r_perr_p  <= 1'b0;
              r_ferr_p  <= 1'b0;
            end
          end
        end
        SHIFT: if (i_sample_tick) begin
          r_tick <= r_tick + TW'(1);
          if (w_last) begin
            r_sym <= r_sym + 4'd1;
            if (w_is_data) begin
              r_shift   <= {r_shift[6:0], r_sync2};
              r_par_acc <= r_par_acc ^ r_sync2;
            end
            if (w_is_par && r_pon && r_sync2 != r_par_acc) r_perr_p <= 1'b1;
            if (w_is_fill && !r_sync2) r_ferr_p <= 1'b1;
            if (r_sym == 4'd9) begin
              r_state <= STOP;
              r_tick  <= '0;
            end
          end
        end
        STOP: if (i_sample_tick) begin
          r_tick <= r_tick + TW'(1);
          if (w_last) begin
            o_rx_valid   <= 1'b1;
            o_rx_data    <= r_w8 ? r_shift : {1'b0, r_shift[6:0]};
            o_parity_err <= r_perr_p;
            o_frame_err  <= r_ferr_p | !r_sync2;
            r_tick       <= '0;
            r_state      <= r_sync2 ? IDLE : WAIT_HIGH;
            o_busy       <= !r_sync2;
          end
        end
        WAIT_HIGH: if (i_sample_tick && r_sync2) begin
          r_state <= IDLE;
          r_tick  <= '0;
          o_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed and randomized frames checked against a symbol-level model.
module tb_uart_frame_rx;
  localparam int OVS = 16;
  localparam int TDIV = 3;
  localparam int BIT = OVS * TDIV;
  logic clk = 1'b0, rst = 1'b1, rx_in = 1'b1, sample_tick = 1'b0, sw0 = 1'b0, sw1 = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, parity_err, frame_err, busy;
  int n_checks = 0, n_fail = 0;
  bit tick_en = 1'b1;
  logic [7:0] q_data[$];
  bit q_pe[$], q_fe[$], q_busy[$];

  uart_frame_rx #(.OVS(OVS)) dut (
    .clk(clk), .rst(rst), .i_rx_in(rx_in), .i_sample_tick(sample_tick),
    .i_sw0(sw0), .i_sw1(sw1), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .o_parity_err(parity_err), .o_frame_err(frame_err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    int c = 0;
    forever begin
      @(negedge clk);
      c = (c + 1) % TDIV;
      sample_tick = tick_en && c == 0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rx_valid === 1'b1) begin
      q_data.push_back(rx_data);
      q_pe.push_back(parity_err);
      q_fe.push_back(frame_err);
      q_busy.push_back(busy);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [0:10] mk(input logic [7:0] d, input bit w8, input bit pon,
                                     input bit flip, input bit fill, input bit stop);
    logic [0:10] s;
    s[0] = 1'b0;
    if (w8) begin
      for (int i = 0; i < 8; i++) s[1+i] = d[7-i];
      s[9] = pon ? (^d) ^ flip : 1'b1;
    end else begin
      for (int i = 0; i < 7; i++) s[1+i] = d[6-i];
      s[8] = pon ? (^d[6:0]) ^ flip : 1'b1;
      s[9] = fill;
    end
    s[10] = stop;
    return s;
  endfunction

  function automatic void model(input logic [0:10] s, input bit w8, input bit pon,
                                output logic [7:0] d, output bit pe, output bit fe);
    int nd, v, ones;
    nd = w8 ? 8 : 7;
    v = 0;
    ones = 0;
    for (int i = 1; i <= nd; i++) begin
      v = v * 2 + int'(s[i]);
      ones += int'(s[i]);
    end
    d = 8'(v);
    pe = pon && (s[nd+1] != 1'(ones & 1));
    fe = (!w8 && !s[9]) || !s[10];
  endfunction

  task automatic send(input logic [0:10] s, input int n, input bit scramble);
    for (int i = 0; i < n; i++) begin
      rx_in = s[i];
      if (scramble && i == 5) begin
        sw0 = 1'($urandom);
        sw1 = 1'($urandom);
      end
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic pop(output bit got, output logic [7:0] d, output bit pe, output bit fe, output bit b);
    got = q_data.size() > 0;
    d = 8'h00; pe = 0; fe = 0; b = 0;
    if (got) begin
      d = q_data.pop_front();
      pe = q_pe.pop_front();
      fe = q_fe.pop_front();
      b = q_busy.pop_front();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rx_data, rx_valid, parity_err, frame_err, busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h v=%b pe=%b fe=%b busy=%b, required all 0",
               rx_data, rx_valid, parity_err, frame_err, busy);
    end
    rst = 1'b0;
    repeat (BIT) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || q_data.size() != 0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b pulses=%0d, required busy=0 pulses=0", busy, q_data.size());
    end
  endtask

  task automatic test_basic_8bit;
    logic [0:10] s;
    logic [7:0] d;
    bit got, pe, fe, b;
    sw1 = 1'b1; sw0 = 1'b1;
    s = 11'b0_10100101_0_1;
    send(s, 11, 0);
    n_checks++;
    if (q_data.size() != 1) begin
      n_fail++;
      $display("FAIL basic8_count: got %0d pulses, required 1", q_data.size());
    end
    pop(got, d, pe, fe, b);
    n_checks++;
    if (d !== 8'hA5 || pe !== 1'b0 || fe !== 1'b0) begin
      n_fail++;
      $display("FAIL basic8_data: got data=%h pe=%b fe=%b, required data=a5 pe=0 fe=0", d, pe, fe);
    end
    n_checks++;
    if (b !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic8_busy: got busy_at_valid=%b busy_now=%b, required 0 and 0", b, busy);
    end
  endtask

  task automatic test_7bit_back_to_back;
    logic [0:10] s1, s2;
    logic [7:0] d;
    bit got, pe, fe, b;
    sw1 = 1'b0; sw0 = 1'b0;
    s1 = 11'b0_0110101_1_1_1;
    s2 = 11'b0_1111111_1_1_1;
    send(s1, 11, 0);
    send(s2, 11, 0);
    n_checks++;
    if (q_data.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d pulses, required 2", q_data.size());
    end
    pop(got, d, pe, fe, b);
    n_checks++;
    if (!got || d !== 8'h35 || pe || fe) begin
      n_fail++;
      $display("FAIL b2b_first: got data=%h pe=%b fe=%b, required data=35 pe=0 fe=0", d, pe, fe);
    end
    pop(got, d, pe, fe, b);
    n_checks++;
    if (!got || d !== 8'h7F || pe || fe) begin
      n_fail++;
      $display("FAIL b2b_second: got data=%h pe=%b fe=%b, required data=7f pe=0 fe=0", d, pe, fe);
    end
  endtask

  task automatic test_parity_err;
    logic [0:10] s;
    logic [7:0] d;
    bit got, pe, fe, b;
    sw1 = 1'b1; sw0 = 1'b1;
    s = 11'b0_10100101_1_1;
    send(s, 11, 0);
    pop(got, d, pe, fe, b);
    n_checks++;
    if (!got || d !== 8'hA5 || pe !== 1'b1 || fe !== 1'b0 || q_data.size() != 0) begin
      n_fail++;
      $display("FAIL parity_err: got valid=%b data=%h pe=%b fe=%b, required valid=1 data=a5 pe=1 fe=0",
               got, d, pe, fe);
    end
  endtask

  task automatic test_break;
    logic [0:10] s;
    logic [7:0] d;
    bit got, pe, fe, b;
    int waited;
    sw1 = 1'b1; sw0 = 1'b1;
    s = 11'b0_10100101_0_0;
    send(s, 11, 0);
    repeat (3 * BIT) @(negedge clk);
    n_checks++;
    if (q_data.size() != 1) begin
      n_fail++;
      $display("FAIL break_count: got %0d pulses, required 1", q_data.size());
    end
    pop(got, d, pe, fe, b);
    n_checks++;
    if (d !== 8'hA5 || pe !== 1'b0 || fe !== 1'b1 || b !== 1'b1) begin
      n_fail++;
      $display("FAIL break_flags: got data=%h pe=%b fe=%b busy=%b, required data=a5 pe=0 fe=1 busy=1",
               d, pe, fe, b);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL break_busy_low: got busy=%b, required 1", busy);
    end
    rx_in = 1'b1;
    waited = 0;
    while (busy !== 1'b0 && waited < 2 * BIT) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL break_release: got busy=%b after %0d clks, required 0", busy, waited);
    end
    repeat (BIT) @(negedge clk);
    n_checks++;
    if (q_data.size() != 0) begin
      n_fail++;
      $display("FAIL break_extra_pulse: got %0d pulses, required 0", q_data.size());
    end
  endtask

  task automatic test_glitch;
    bit seen = 0;
    rx_in = 1'b0;
    repeat (OVS / 4 * TDIV) begin
      @(negedge clk);
      seen |= busy;
    end
    rx_in = 1'b1;
    repeat (BIT) begin
      @(negedge clk);
      seen |= busy;
    end
    n_checks++;
    if (!seen || busy !== 1'b0 || q_data.size() != 0) begin
      n_fail++;
      $display("FAIL glitch: got busy_seen=%b busy=%b pulses=%0d, required 1 0 0", seen, busy, q_data.size());
    end
  endtask

  task automatic test_reset_midframe;
    logic [0:10] s;
    logic [7:0] d;
    bit got, pe, fe, b;
    sw1 = 1'b1; sw0 = 1'b0;
    s = 11'b0_01011010_1_1;
    send(s, 5, 0);
    rx_in = s[5];
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({rx_data, rx_valid, parity_err, frame_err, busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL midframe_reset: got data=%h v=%b pe=%b fe=%b busy=%b, required all 0",
               rx_data, rx_valid, parity_err, frame_err, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    n_checks++;
    if (q_data.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_no_valid: got pulses=%0d busy=%b, required 0 0", q_data.size(), busy);
    end
    send(s, 11, 0);
    pop(got, d, pe, fe, b);
    n_checks++;
    if (!got || d !== 8'h5A || pe || fe) begin
      n_fail++;
      $display("FAIL post_reset_frame: got valid=%b data=%h pe=%b fe=%b, required valid=1 data=5a pe=0 fe=0",
               got, d, pe, fe);
    end
  endtask

  task automatic test_random;
    logic [0:10] s;
    logic [7:0] d, ed, td;
    bit got, pe, fe, b, epe, efe, w8, pon;
    for (int n = 0; n < 12; n++) begin
      w8 = 1'($urandom);
      pon = 1'($urandom);
      td = 8'($urandom);
      s = mk(td, w8, pon, $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0, 1'b1);
      sw1 = w8; sw0 = pon;
      send(s, 11, 1);
      model(s, w8, pon, ed, epe, efe);
      pop(got, d, pe, fe, b);
      n_checks++;
      if (!got || q_data.size() != 0 || d !== ed || pe !== epe || fe !== efe || b !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d] w8=%b par=%b: got valid=%b data=%h pe=%b fe=%b busy=%b, required valid=1 data=%h pe=%b fe=%b busy=0",
                 n, w8, pon, got, d, pe, fe, b, ed, epe, efe);
      end
      q_data.delete(); q_pe.delete(); q_fe.delete(); q_busy.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic_8bit();
    test_7bit_back_to_back();
    test_parity_err();
    test_break();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
